// File: rtl/ring_monitor.sv
// ring_monitor
//   Watches the output of an upstream one-hot ring counter (1,2,4,8,1,...).
//   Each clock it encodes the active bit to a binary index, checks that the
//   sample is one-hot and that it is the rotate-left of the previous sample,
//   locks onto the sequence after LOCK_LEN consecutive legal steps, counts
//   completed rotations while locked and latches a fault on any illegal code
//   or step until clr_err is raised.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   ring_in    in   [NUM_BITS]    ring counter output, sampled every edge
//   load_seen  in   upstream load strobe, aligned with the loaded ring_in
//   clr_err    in   leaves FAULT when high at an edge
//   idx        out  [clog2(N)]    index of the set bit of the last sample
//   valid_code out  last sample was exactly one-hot
//   locked     out  monitor is in LOCKED
//   err        out  monitor is in FAULT
//   rot_count  out  [CNT_W]       rotations completed while locked
//   rot_pulse  out  one-cycle strobe per counted rotation
module ring_monitor #(
    parameter int NUM_BITS = 4,
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_BITS-1:0]         ring_in,
    input  logic                        load_seen,
    input  logic                        clr_err,
    output logic [$clog2(NUM_BITS)-1:0] idx,
    output logic                        valid_code,
    output logic                        locked,
    output logic                        err,
    output logic [CNT_W-1:0]            rot_count,
    output logic                        rot_pulse
);

    localparam int IDX_W  = $clog2(NUM_BITS);
    localparam int GOOD_W = $clog2(LOCK_LEN + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] prev_q, prev_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                valid_code_q, valid_code_d;
    logic [CNT_W-1:0]    rot_count_q, rot_count_d;
    logic                rot_pulse_q, rot_pulse_d;

    logic                one_hot;
    logic                legal_step;
    logic                wrap;
    logic [IDX_W-1:0]    idx_enc;
    logic [NUM_BITS-1:0] prev_rotl;
    logic [GOOD_W-1:0]   good_inc;

    // Sample classification
    always_comb begin
        one_hot    = $onehot(ring_in);
        prev_rotl  = {prev_q[NUM_BITS-2:0], prev_q[NUM_BITS-1]};
        // A held value can never equal its own rotation when one-hot, so
        // holds fall out as illegal without a separate check.
        legal_step = one_hot && (ring_in == prev_rotl);
        wrap       = prev_q[NUM_BITS-1] && ring_in[0];
        good_inc   = good_cnt_q + GOOD_W'(1);

        idx_enc = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (ring_in[i]) begin
                idx_enc = IDX_W'(i);
            end
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        rot_count_d  = rot_count_q;
        rot_pulse_d  = 1'b0;
        prev_d       = ring_in;
        valid_code_d = one_hot;
        idx_d        = one_hot ? idx_enc : '0;

        unique case (state_q)
            HUNT: begin
                if (one_hot) begin
                    state_d    = SYNC;
                    good_cnt_d = '0;
                end
            end
            SYNC: begin
                if (!one_hot) begin
                    state_d    = HUNT;
                    good_cnt_d = '0;
                end else if (load_seen) begin
                    good_cnt_d = '0;
                end else if (legal_step) begin
                    if (good_inc == GOOD_W'(LOCK_LEN)) begin
                        // The wrap on this edge is deliberately not counted.
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (!one_hot) begin
                    state_d = FAULT;
                end else if (load_seen) begin
                    // Loaded value is accepted; it becomes prev below.
                    state_d = LOCKED;
                end else if (legal_step) begin
                    if (wrap) begin
                        rot_count_d = rot_count_q + CNT_W'(1);
                        rot_pulse_d = 1'b1;
                    end
                end else begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_d    = HUNT;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            good_cnt_q   <= '0;
            idx_q        <= '0;
            valid_code_q <= 1'b0;
            rot_count_q  <= '0;
            rot_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_cnt_q   <= good_cnt_d;
            idx_q        <= idx_d;
            valid_code_q <= valid_code_d;
            rot_count_q  <= rot_count_d;
            rot_pulse_q  <= rot_pulse_d;
        end
    end

    assign idx        = idx_q;
    assign valid_code = valid_code_q;
    assign locked     = (state_q == LOCKED);
    assign err        = (state_q == FAULT);
    assign rot_count  = rot_count_q;
    assign rot_pulse  = rot_pulse_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Testbench for ring_monitor: directed sequence followed by randomized
// traffic, all outputs compared against a behavioural model each edge.
module tb_ring_monitor;

    localparam int N    = 4;
    localparam int LL   = 4;
    localparam int CW   = 8;
    localparam int MASK = (1 << N) - 1;

    localparam int M_HUNT   = 0;
    localparam int M_SYNC   = 1;
    localparam int M_LOCKED = 2;
    localparam int M_FAULT  = 3;

    logic          clk;
    logic          reset;
    logic [N-1:0]  ring_in;
    logic          load_seen;
    logic          clr_err;
    logic [1:0]    idx;
    logic          valid_code;
    logic          locked;
    logic          err;
    logic [CW-1:0] rot_count;
    logic          rot_pulse;

    int tests;
    int fails;

    // Reference model state
    int m_state;
    int m_prev;
    int m_good;
    int m_idx;
    int m_vld;
    int m_rot;
    int m_pulse;

    ring_monitor #(.NUM_BITS(N), .LOCK_LEN(LL), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ring_in    (ring_in),
        .load_seen  (load_seen),
        .clr_err    (clr_err),
        .idx        (idx),
        .valid_code (valid_code),
        .locked     (locked),
        .err        (err),
        .rot_count  (rot_count),
        .rot_pulse  (rot_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rotl(input int p);
        return ((p << 1) | (p >> (N - 1))) & MASK;
    endfunction

    task automatic m_reset();
        m_state = M_HUNT; m_prev = 0; m_good = 0;
        m_idx = 0; m_vld = 0; m_rot = 0; m_pulse = 0;
    endtask

    task automatic model_edge(input int r, input bit ld, input bit clr);
        bit one;
        bit legal;
        bit wr;
        one   = ($countones(r) == 1);
        legal = (r == rotl(m_prev));
        wr    = (((m_prev >> (N - 1)) & 1) == 1) && ((r & 1) == 1);
        m_vld = one;
        m_idx = 0;
        if (one) begin
            for (int b = 0; b < N; b++) if (((r >> b) & 1) == 1) m_idx = b;
        end
        m_pulse = 0;
        case (m_state)
            M_HUNT:   if (one) begin m_state = M_SYNC; m_good = 0; end
            M_SYNC: begin
                if (!one) begin m_state = M_HUNT; m_good = 0; end
                else if (ld) m_good = 0;
                else if (legal) begin
                    m_good++;
                    if (m_good == LL) begin m_state = M_LOCKED; m_good = 0; end
                end else m_good = 0;
            end
            M_LOCKED: begin
                if (!one) m_state = M_FAULT;
                else if (ld) ;
                else if (legal) begin
                    if (wr) begin m_rot = (m_rot + 1) % (1 << CW); m_pulse = 1; end
                end else m_state = M_FAULT;
            end
            default:  if (clr) begin m_state = M_HUNT; m_good = 0; end
        endcase
        m_prev = r;
    endtask

    task automatic compare_all();
        check("idx", 32'(idx), 32'(m_idx));
        check("valid_code", 32'(valid_code), 32'(m_vld));
        check("locked", 32'(locked), 32'(m_state == M_LOCKED));
        check("err", 32'(err), 32'(m_state == M_FAULT));
        check("rot_count", 32'(rot_count), 32'(m_rot));
        check("rot_pulse", 32'(rot_pulse), 32'(m_pulse));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input int r, input bit ld, input bit clr);
        ring_in   = N'(r);
        load_seen = ld;
        clr_err   = clr;
        @(posedge clk);
        model_edge(r, ld, clr);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        int seq [9];
        int exp_idx [9];
        int r;
        int sel;
        bit ld;
        bit clr;

        tests = 0;
        fails = 0;
        reset = 1'b1;
        ring_in = '0;
        load_seen = 1'b0;
        clr_err = 1'b0;
        m_reset();

        repeat (2) @(negedge clk);
        check("rst_idx", 32'(idx), 0);
        check("rst_valid", 32'(valid_code), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rot", 32'(rot_count), 0);
        check("rst_pulse", 32'(rot_pulse), 0);
        reset = 1'b0;

        // Basic lock-up and first counted rotation
        seq     = '{1, 2, 4, 8, 1, 2, 4, 8, 1};
        exp_idx = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        for (int k = 0; k < 9; k++) begin
            step(seq[k], 1'b0, 1'b0);
            check("seq_idx", 32'(idx), 32'(exp_idx[k]));
            if (k == 3) check("seq_notlocked_e4", 32'(locked), 0);
            if (k == 4) begin
                check("seq_locked_e5", 32'(locked), 1);
                check("seq_nopulse_e5", 32'(rot_pulse), 0);
                check("seq_rot_e5", 32'(rot_count), 0);
            end
        end
        check("seq_pulse_e9", 32'(rot_pulse), 1);
        check("seq_rot_e9", 32'(rot_count), 1);

        // Bad code while locked, fault persistence and clear
        step(4'b0110, 1'b0, 1'b0);
        check("bad_err", 32'(err), 1);
        check("bad_locked", 32'(locked), 0);
        check("bad_valid", 32'(valid_code), 0);
        check("bad_idx", 32'(idx), 0);
        r = 2;
        for (int k = 0; k < 10; k++) begin
            step(r, 1'b0, 1'b0);
            r = rotl(r);
        end
        check("fault_hold", 32'(err), 1);
        step(2, 1'b0, 1'b1);
        check("clr_err_low", 32'(err), 0);
        check("clr_unlocked", 32'(locked), 0);
        step(4, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        step(4, 1'b0, 1'b0);
        check("relock_after_clr", 32'(locked), 1);
        check("rot_kept", 32'(rot_count), 1);

        // Load accepted while locked
        step(8, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        step(8, 1'b1, 1'b0);
        check("load_locked", 32'(locked), 1);
        check("load_err", 32'(err), 0);
        check("load_idx", 32'(idx), 3);
        step(1, 1'b0, 1'b0);
        check("load_wrap_pulse", 32'(rot_pulse), 1);
        check("load_wrap_rot", 32'(rot_count), 3);

        // Skip without load, then hold
        step(2, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        check("skip_fault", 32'(err), 1);
        step(1, 1'b0, 1'b1);
        step(2, 1'b0, 1'b0);
        step(4, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        check("relock2", 32'(locked), 1);
        step(4, 1'b0, 1'b0);
        check("hold_first_ok", 32'(locked), 1);
        step(4, 1'b0, 1'b0);
        check("hold_fault", 32'(err), 1);

        // Build rot_count up to 5 then reset asynchronously
        step(1, 1'b0, 1'b1);
        step(2, 1'b0, 1'b0);
        step(4, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(4, 1'b0, 1'b0);
            step(8, 1'b0, 1'b0);
            step(1, 1'b0, 1'b0);
            step(2, 1'b0, 1'b0);
        end
        check("pre_rst_rot", 32'(rot_count), 5);
        check("pre_rst_locked", 32'(locked), 1);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check("arst_locked", 32'(locked), 0);
        check("arst_err", 32'(err), 0);
        check("arst_rot", 32'(rot_count), 0);
        check("arst_idx", 32'(idx), 0);
        check("arst_valid", 32'(valid_code), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        step(4, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        check("post_rst_not_yet", 32'(locked), 0);
        step(1, 1'b0, 1'b0);
        check("post_rst_locked", 32'(locked), 1);

        // Rotation counter rollover
        for (int k = 0; k < 255; k++) begin
            step(2, 1'b0, 1'b0);
            step(4, 1'b0, 1'b0);
            step(8, 1'b0, 1'b0);
            step(1, 1'b0, 1'b0);
        end
        check("rot_255", 32'(rot_count), 255);
        step(2, 1'b0, 1'b0);
        step(4, 1'b0, 1'b0);
        step(8, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        check("rot_wrap_zero", 32'(rot_count), 0);
        check("rot_wrap_pulse", 32'(rot_pulse), 1);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            sel = int'($urandom_range(0, 99));
            ld  = 1'b0;
            clr = ($urandom_range(0, 9) == 0);
            if ($countones(m_prev) == 1 && sel < 75) begin
                r = rotl(m_prev);
            end else if (sel < 83) begin
                r = int'($urandom_range(0, MASK));
            end else if (sel < 90) begin
                r  = 1 << $urandom_range(0, N - 1);
                ld = 1'b1;
            end else if (sel < 95) begin
                r = m_prev;
            end else begin
                r = 1 << $urandom_range(0, N - 1);
            end
            step(r, ld, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
